zero_count_stream: RTL and testbench

Streaming, parametrised zero counter. It accepts a multi-beat word as DATA_WIDTH-bit beats, LSB beat first, over a valid/ready handshake. Per word it returns either the trailing-zero or the leading-zero count of the full concatenated word, plus an all-zero flag and an overflow error. It sits in the datapath wherever the single-cycle 8-bit zero counter is too narrow, or where operands arrive serially.

---
 rtl/zero_count_stream.sv | 171 +++++++++++++++++
 tb/tb_zero_count_stream.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/zero_count_stream.sv
// zero_count_stream: streaming trailing/leading zero counter over a multi-beat
// word delivered LSB beat first. One result per word, with an all-zero flag and
// a truncation error when the word runs past MAX_BEATS without in_last.
//
// Handshake: a beat transfers on a rising edge where in_valid & in_ready; a
// result transfers on a rising edge where out_valid & out_ready. out_* are held
// stable while out_valid=1 and out_ready=0; in_ready is low while a result waits.
module zero_count_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BEATS  = 4,
    localparam int CNT_W     = $clog2(DATA_WIDTH*MAX_BEATS+1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic                  in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      out_count,
    output logic                  out_all_zero,
    output logic                  out_err
);

    localparam int BC_W = $clog2(MAX_BEATS+1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   acc;
    logic               locked;
    logic               all_zero;
    logic               mode;
    logic [BC_W-1:0]    beat_cnt;

    // Trailing zeros of one beat; DATA_WIDTH for an all-zero beat.
    function automatic logic [CNT_W-1:0] tz_f(input logic [DATA_WIDTH-1:0] b);
        logic [CNT_W-1:0] n;
        logic             hit;
        n   = '0;
        hit = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (!hit) begin
                if (b[i]) hit = 1'b1;
                else      n   = n + CNT_W'(1);
            end
        end
        return n;
    endfunction

    // Leading zeros of one beat; DATA_WIDTH for an all-zero beat.
    function automatic logic [CNT_W-1:0] lz_f(input logic [DATA_WIDTH-1:0] b);
        logic [CNT_W-1:0] n;
        logic             hit;
        n   = '0;
        hit = 1'b0;
        for (int i = DATA_WIDTH-1; i >= 0; i--) begin
            if (!hit) begin
                if (b[i]) hit = 1'b1;
                else      n   = n + CNT_W'(1);
            end
        end
        return n;
    endfunction

    // Beat acceptance is blocked during reset and while a result is pending.
    assign in_ready = !rst && (state != S_DONE);

    logic               beat_fire;
    logic               start_word;
    logic               take_beat;
    logic [CNT_W-1:0]   acc_base;
    logic               locked_base;
    logic               allz_base;
    logic               mode_eff;
    logic [BC_W-1:0]    cnt_base;
    logic [CNT_W-1:0]   acc_nxt;
    logic               locked_nxt;
    logic               allz_nxt;
    logic [BC_W-1:0]    cnt_nxt;
    logic               beat_zero;
    logic               hit_max;
    logic               term;
    logic               err_nxt;

    // Next accumulator values for the beat on the bus; a first beat starts
    // from a clean word so a restart in ACCUM drops the partial word.
    always_comb begin
        beat_fire   = in_valid && in_ready;
        start_word  = in_first;
        take_beat   = beat_fire && (in_first || (state == S_ACCUM));
        acc_base    = start_word ? '0   : acc;
        locked_base = start_word ? 1'b0 : locked;
        allz_base   = start_word ? 1'b1 : all_zero;
        mode_eff    = start_word ? in_mode : mode;
        cnt_base    = start_word ? '0   : beat_cnt;
        beat_zero   = (in_data == '0);
        acc_nxt     = acc_base;
        locked_nxt  = locked_base;
        if (!mode_eff) begin
            if (!locked_base) begin
                acc_nxt    = acc_base + tz_f(in_data);
                locked_nxt = !beat_zero;
            end
        end else begin
            if (!beat_zero) acc_nxt = lz_f(in_data);
            else            acc_nxt = acc_base + CNT_W'(DATA_WIDTH);
        end
        allz_nxt = allz_base && beat_zero;
        cnt_nxt  = cnt_base + BC_W'(1);
        hit_max  = (cnt_nxt == BC_W'(MAX_BEATS));
        term     = in_last || hit_max;
        err_nxt  = !in_last && hit_max;
    end

    // Control FSM with registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            acc          <= '0;
            locked       <= 1'b0;
            all_zero     <= 1'b0;
            mode         <= 1'b0;
            beat_cnt     <= '0;
            out_valid    <= 1'b0;
            out_count    <= '0;
            out_all_zero <= 1'b0;
            out_err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_ACCUM: begin
                    if (take_beat) begin
                        acc      <= acc_nxt;
                        locked   <= locked_nxt;
                        all_zero <= allz_nxt;
                        mode     <= mode_eff;
                        beat_cnt <= cnt_nxt;
                        if (term) begin
                            state        <= S_DONE;
                            out_valid    <= 1'b1;
                            out_count    <= acc_nxt;
                            out_all_zero <= allz_nxt;
                            out_err      <= err_nxt;
                        end else begin
                            state <= S_ACCUM;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        beat_cnt  <= '0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zero_count_stream.sv
// Directed bench for zero_count_stream (DATA_WIDTH=8, MAX_BEATS=4).
module tb_zero_count_stream;

    localparam int DW = 8;
    localparam int MB = 4;
    localparam int CW = 6;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_first;
    logic          in_last;
    logic          in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_count;
    logic          out_all_zero;
    logic          out_err;

    int n_checks;
    int n_fail;

    zero_count_stream #(.DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_first     (in_first),
        .in_last      (in_last),
        .in_mode      (in_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_count    (out_count),
        .out_all_zero (out_all_zero),
        .out_err      (out_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one beat and wait (bounded) for it to transfer; then check whether
    // a result appeared exactly one cycle after acceptance.
    task automatic send_beat(input string tag, input logic [DW-1:0] d, input logic f,
                             input logic l, input logic m, input logic term_exp);
        logic done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_first = f;
        in_last  = l;
        in_mode  = m;
        for (int i = 0; i < 20 && !done; i++) begin
            if (in_ready) done = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        if (!done) check({tag, "_accept_timeout"}, 0, 1);
        check({tag, "_out_valid"}, out_valid, term_exp);
    endtask

    // Check a pending result, then complete the handshake.
    task automatic take_result(input string tag, input int cnt, input logic az, input logic err);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_count"}, out_count, cnt);
        check({tag, "_all_zero"}, out_all_zero, az);
        check({tag, "_err"}, out_err, err);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_count", out_count, 0);
        check("rst_all_zero", out_all_zero, 0);
        check("rst_err", out_err, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", in_ready, 1);

        // single beat, trailing
        send_beat("t1", 8'b1001_0000, 1, 1, 0, 1);
        take_result("t1", 4, 0, 0);

        // 00,00,10 trailing -> 20 ; leading -> 3
        send_beat("t2a", 8'h00, 1, 0, 0, 0);
        send_beat("t2b", 8'h00, 0, 0, 0, 0);
        send_beat("t2c", 8'h10, 0, 1, 0, 1);
        take_result("t2", 20, 0, 0);
        send_beat("l2a", 8'h00, 1, 0, 1, 0);
        send_beat("l2b", 8'h00, 0, 0, 1, 0);
        send_beat("l2c", 8'h10, 0, 1, 1, 1);
        take_result("l2", 3, 0, 0);

        // leading 01,00 -> 15
        send_beat("l3a", 8'h01, 1, 0, 1, 0);
        send_beat("l3b", 8'h00, 0, 1, 1, 1);
        take_result("l3", 15, 0, 0);

        // four zero beats trailing, last on fourth -> 32, all zero, no error
        send_beat("t4a", 8'h00, 1, 0, 0, 0);
        send_beat("t4b", 8'h00, 0, 0, 0, 0);
        send_beat("t4c", 8'h00, 0, 0, 0, 0);
        send_beat("t4d", 8'h00, 0, 1, 0, 1);
        take_result("t4", 32, 1, 0);

        // single all-zero beat in leading mode -> 8
        send_beat("l5", 8'h00, 1, 1, 1, 1);
        take_result("l5", 8, 1, 0);

        // mode on non-first beats is ignored: trailing 00 then 04 -> 10
        send_beat("m6a", 8'h00, 1, 0, 0, 0);
        send_beat("m6b", 8'h04, 0, 1, 1, 1);
        take_result("m6", 10, 0, 0);

        // trailing locks on first nonzero beat: 00, 01, 00 -> 8
        send_beat("k7a", 8'h00, 1, 0, 0, 0);
        send_beat("k7b", 8'h01, 0, 0, 0, 0);
        send_beat("k7c", 8'h00, 0, 1, 0, 1);
        take_result("k7", 8, 0, 0);

        // backpressure
        send_beat("bp", 8'b1001_0000, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check("bp_count", out_count, 4);
            tick();
        end
        take_result("bp", 4, 0, 0);

        // overflow: five zero beats, none last
        send_beat("ov1", 8'h00, 1, 0, 0, 0);
        send_beat("ov2", 8'h00, 0, 0, 0, 0);
        send_beat("ov3", 8'h00, 0, 0, 0, 0);
        send_beat("ov4", 8'h00, 0, 0, 0, 1);
        take_result("ov", 32, 1, 1);
        send_beat("ov5", 8'h00, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check("ov5_dropped", out_valid, 0);
            tick();
        end

        // restart with mode re-latch: leading 00, then first 80 trailing -> 7
        send_beat("rs1", 8'h00, 1, 0, 1, 0);
        send_beat("rs2", 8'h80, 1, 1, 0, 1);
        take_result("rs", 7, 0, 0);

        // restart: 00 then first 08 last -> 3
        send_beat("rs3", 8'h00, 1, 0, 0, 0);
        send_beat("rs4", 8'h08, 1, 1, 0, 1);
        take_result("rs_b", 3, 0, 0);

        // reset during ACCUM, then a fresh word 02 -> 1
        send_beat("rr1", 8'h00, 1, 0, 0, 0);
        send_beat("rr2", 8'h00, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        check("rr_rst_valid", out_valid, 0);
        rst = 1'b0;
        tick();
        check("rr_after_valid", out_valid, 0);
        send_beat("rr3", 8'h02, 1, 1, 0, 1);
        take_result("rr", 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
